// File: rtl/vga_line_fetcher.sv
// Double-buffered line fetcher: line n of the frame buffer is fetched into bank n[0]
// one line ahead of display, while the other bank feeds the VGA timing block with zero latency.
module vga_line_fetcher #(
   parameter int unsigned H_ACT   = 640,
   parameter int unsigned V_ACT   = 480,
   parameter logic [21:0] FB_BASE = 22'h0
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iTopOfScreen,
   input  logic        iRequest,
   input  logic [9:0]  iCurrent_X,
   input  logic [9:0]  iCurrent_Y,
   output logic [3:0]  oRed,
   output logic [3:0]  oGreen,
   output logic [3:0]  oBlue,
   output logic [21:0] oMemAddress,
   output logic        oMemRead,
   input  logic        iMemWaitRequest,
   input  logic [15:0] iMemReadData,
   input  logic        iMemReadDataValid,
   output logic        oUnderrun
);
   localparam int unsigned CW = $clog2(H_ACT + 1);
   localparam int unsigned AW = $clog2(H_ACT);
   localparam logic [CW-1:0] W_LAST = CW'(H_ACT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

   state_t        r_state;
   logic [9:0]    r_line;
   logic          r_fill_bank;
   logic [CW-1:0] r_issue_cnt;
   logic [CW-1:0] r_recv_cnt;
   logic [CW-1:0] r_outstanding;
   logic [11:0]   r_bank0 [H_ACT];
   logic [11:0]   r_bank1 [H_ACT];

   logic          w_accept;
   logic          w_trigger;
   logic          w_last;
   logic          w_wr;
   logic          w_start;
   logic          w_underrun;
   logic [9:0]    w_trig_line;
   logic [9:0]    w_start_line;
   logic [CW-1:0] w_out_next;
   logic [11:0]   w_pix;
   logic [13:0]   w_unused;

   function automatic logic [21:0] f_line_base(input logic [9:0] line);
      return FB_BASE + 22'(line) * 22'(H_ACT);
   endfunction

   assign w_accept    = oMemRead & ~iMemWaitRequest;
   assign w_trigger   = iTopOfScreen |
                        (iRequest & (iCurrent_X == '0) & (iCurrent_Y < 10'(V_ACT - 1)));
   assign w_trig_line = iTopOfScreen ? '0 : iCurrent_Y + 10'd1;
   assign w_last      = (r_state == ISSUE) & iMemReadDataValid & (r_recv_cnt == W_LAST);
   assign w_wr        = (r_state == ISSUE) & iMemReadDataValid;
   assign w_unused    = {iMemReadData[15:12], iCurrent_X};

   always_comb begin
      w_out_next = r_outstanding;
      if (w_accept && !iMemReadDataValid)
         w_out_next = r_outstanding + CW'(1);
      else if (!w_accept && iMemReadDataValid && r_outstanding != '0)
         w_out_next = r_outstanding - CW'(1);
   end

   // The abort decision uses next-cycle outstanding so a read accepted in the
   // trigger cycle is still flushed rather than landing in the new line.
   always_comb begin
      w_start      = 1'b0;
      w_underrun   = 1'b0;
      w_start_line = w_trig_line;
      unique case (r_state)
         IDLE:  w_start = w_trigger;
         ISSUE: begin
            w_start    = w_trigger & (w_last | (w_out_next == '0));
            w_underrun = w_trigger & ~w_last;
         end
         FLUSH: begin
            w_start    = (w_out_next == '0);
            w_underrun = w_trigger;
            if (!w_trigger) w_start_line = r_line;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state       <= IDLE;
         r_line        <= '0;
         r_fill_bank   <= 1'b0;
         r_issue_cnt   <= '0;
         r_recv_cnt    <= '0;
         r_outstanding <= '0;
         oMemRead      <= 1'b0;
         oMemAddress   <= '0;
         oUnderrun     <= 1'b0;
      end else begin
         r_outstanding <= w_out_next;
         if (w_underrun) oUnderrun <= 1'b1;
         if (w_wr) r_recv_cnt <= r_recv_cnt + CW'(1);
         if (w_accept) begin
            r_issue_cnt <= r_issue_cnt + CW'(1);
            oMemAddress <= oMemAddress + 22'd1;
            oMemRead    <= (r_issue_cnt != W_LAST);
         end
         if (w_start) begin
            r_state     <= ISSUE;
            r_line      <= w_start_line;
            r_fill_bank <= w_start_line[0];
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            oMemRead    <= 1'b1;
            oMemAddress <= f_line_base(w_start_line);
         end else if (w_trigger && r_state != IDLE) begin
            r_state  <= FLUSH;
            r_line   <= w_trig_line;
            oMemRead <= 1'b0;
         end else if (w_last) begin
            r_state <= IDLE;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (w_wr && !r_fill_bank) r_bank0[r_recv_cnt[AW-1:0]] <= iMemReadData[11:0];
      if (w_wr &&  r_fill_bank) r_bank1[r_recv_cnt[AW-1:0]] <= iMemReadData[11:0];
   end

   assign w_pix = iCurrent_Y[0] ? r_bank1[iCurrent_X[AW-1:0]] : r_bank0[iCurrent_X[AW-1:0]];
   assign {oRed, oGreen, oBlue} = iRequest ? w_pix : 12'h000;

endmodule
